// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: keeps at most one memory request in flight and holds
// the fetched word for the decoder. Redirects flush the held word and drain stale responses.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_Write,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        fetch_valid
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;
    localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            req_q, req_d;

    // Next-state and output computation; redirect outranks every other event.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;

        if (redirect) begin
            pc_d    = redirect_pc & WORD_MASK;
            valid_d = 1'b0;
            instr_d = NOP_INSN;
            unique case (state_q)
                FETCH:   state_d = imem_ready  ? DRAIN : FETCH;
                WAIT:    state_d = imem_rvalid ? FETCH : DRAIN;
                HOLD:    state_d = FETCH;
                DRAIN:   state_d = imem_rvalid ? FETCH : DRAIN;
                default: state_d = FETCH;
            endcase
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem_ready) state_d = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        state_d  = HOLD;
                    end
                end
                HOLD: begin
                    if (PC_Write) begin
                        valid_d = 1'b0;
                        pc_d    = pc_q + XLEN'(4);
                        state_d = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end

        req_d = (state_d == FETCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            pc_out_q <= '0;
            instr_q  <= NOP_INSN;
            valid_q  <= 1'b0;
            req_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            req_q    <= req_d;
        end
    end

    assign imem_req        = req_q;
    assign imem_addr       = pc_q;
    assign pc_out          = pc_out_q;
    assign instruction_out = instr_q;
    assign fetch_valid     = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a transaction-level model (outstanding /
// stale / held flags) is compared every cycle, plus hand-computed literal checks.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        PC_Write;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        fetch_valid;

    int vectors = 0;
    int miscompares = 0;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .PC_Write(PC_Write), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_out(pc_out), .instruction_out(instruction_out), .fetch_valid(fetch_valid)
    );

    always #5 clk = ~clk;

    // Transaction-level model: a request is outstanding or not, its response is
    // wanted or stale, and a fetched word is either held for the decoder or not.
    logic [31:0] m_pc, m_pc_out, m_instr;
    logic        m_held, m_outstanding, m_stale, m_live;

    function automatic logic m_req();
        return !m_outstanding && !m_held;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 32'h0; m_pc_out = 32'h0; m_instr = NOP;
            m_held = 1'b0; m_outstanding = 1'b0; m_stale = 1'b0; m_live = 1'b1;
        end else if (m_live) begin
            if (redirect) begin
                if (m_req() && imem_ready) begin
                    m_outstanding = 1'b1; m_stale = 1'b1;
                end else if (m_outstanding) begin
                    if (imem_rvalid) m_outstanding = 1'b0;
                    else m_stale = 1'b1;
                end
                m_pc = {redirect_pc[31:2], 2'b00};
                m_held = 1'b0; m_instr = NOP;
            end else if (m_req() && imem_ready) begin
                m_outstanding = 1'b1; m_stale = 1'b0;
            end else if (m_outstanding && imem_rvalid) begin
                if (!m_stale) begin
                    m_instr = imem_rdata; m_pc_out = m_pc; m_held = 1'b1;
                end
                m_outstanding = 1'b0;
            end else if (m_held && PC_Write) begin
                m_held = 1'b0;
                m_pc = m_pc + 32'd4;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_live === 1'b1 && !rst) begin
            cmp("imem_req", 32'(imem_req), 32'(m_req()));
            if (m_req()) cmp("imem_addr", imem_addr, m_pc);
            cmp("fetch_valid", 32'(fetch_valid), 32'(m_held));
            cmp("instruction_out", instruction_out, m_instr);
            cmp("pc_out", pc_out, m_pc_out);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        PC_Write = 1'b0; redirect = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
    endtask

    // Accept a request, then return data one cycle later.
    task automatic fetch_one(input logic [31:0] word);
        imem_ready = 1'b1; step(1);
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = word; step(1);
        imem_rvalid = 1'b0;
    endtask

    task automatic consume();
        PC_Write = 1'b1; step(1);
        PC_Write = 1'b0;
    endtask

    initial begin
        m_live = 1'b0;
        rst = 1'b1; redirect_pc = 32'h0; imem_rdata = 32'h0;
        idle();
        step(2);
        rst = 1'b0;
        cmp("rst_req", 32'(imem_req), 32'd1);
        cmp("rst_addr", imem_addr, 32'h0);
        cmp("rst_instr", instruction_out, NOP);
        cmp("rst_valid", 32'(fetch_valid), 32'd0);

        // Basic fetch
        fetch_one(32'h0050_0093);
        cmp("basic_pc_out", pc_out, 32'h0);
        cmp("basic_instr", instruction_out, 32'h0050_0093);
        cmp("basic_valid", 32'(fetch_valid), 32'd1);
        consume();
        cmp("basic_valid_drop", 32'(fetch_valid), 32'd0);
        cmp("basic_next_addr", imem_addr, 32'h4);

        // Stall in HOLD
        fetch_one(32'h00A0_0113);
        for (int i = 0; i < 5; i++) begin
            step(1);
            cmp("stall_req", 32'(imem_req), 32'd0);
            cmp("stall_instr", instruction_out, 32'h00A0_0113);
            cmp("stall_pc_out", pc_out, 32'h4);
        end
        consume();
        cmp("stall_next_addr", imem_addr, 32'h8);

        // Redirect in WAIT with late response
        imem_ready = 1'b1; step(1);
        imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103; step(1);
        redirect = 1'b0;
        cmp("drain_req", 32'(imem_req), 32'd0);
        step(1);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; step(1);
        imem_rvalid = 1'b0;
        cmp("drain_valid", 32'(fetch_valid), 32'd0);
        cmp("drain_instr", instruction_out, NOP);
        cmp("drain_addr", imem_addr, 32'h100);
        fetch_one(32'h0010_0073);
        cmp("redir_pc_out", pc_out, 32'h100);
        consume();

        // Redirect, rvalid and stall together in WAIT
        imem_ready = 1'b1; step(1);
        imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111; step(1);
        idle();
        cmp("simul_req", 32'(imem_req), 32'd1);
        cmp("simul_addr", imem_addr, 32'h200);
        cmp("simul_instr", instruction_out, NOP);

        // Redirect in FETCH while the stale request is accepted
        imem_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h42; step(1);
        idle();
        step(1);
        imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222; step(1);
        imem_rvalid = 1'b0;
        cmp("fetch_redir_addr", imem_addr, 32'h40);

        // Wrap-around
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; step(1);
        redirect = 1'b0;
        fetch_one(32'h0000_0533);
        cmp("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
        consume();
        cmp("wrap_addr", imem_addr, 32'h0);

        // Reset in WAIT, overriding redirect and PC_Write
        redirect = 1'b1; redirect_pc = 32'h300; step(1);
        redirect = 1'b0;
        fetch_one(32'h0030_0193);
        consume();
        imem_ready = 1'b1; step(1);
        imem_ready = 1'b0;
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h500; PC_Write = 1'b1; step(1);
        rst = 1'b0; idle();
        cmp("wrst_req", 32'(imem_req), 32'd1);
        cmp("wrst_addr", imem_addr, 32'h0);
        cmp("wrst_pc_out", pc_out, 32'h0);
        cmp("wrst_instr", instruction_out, NOP);
        cmp("wrst_valid", 32'(fetch_valid), 32'd0);
        fetch_one(32'h0040_0213);
        consume();
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00000000: PC loaded on reset (bits [1:0] zero).
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-003 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have port PC_Write, input, 1: 1 = downstream accepts the held instruction; 0 = stall.
REQ-005 The block SHALL have port redirect, input, 1: branch/jump taken; restart fetch at redirect_pc.
REQ-006 The block SHALL have port redirect_pc, input, 32: redirect target.
REQ-007 The block SHALL have port imem_req, output, 1: fetch request valid.
REQ-008 The block SHALL have port imem_addr, output, 32: fetch address, meaningful only while imem_req=1.
REQ-009 The block SHALL have port imem_ready, input, 1: memory accepts the request this cycle.
REQ-010 The block SHALL have port imem_rvalid, input, 1: read data valid.
REQ-011 The block SHALL have port imem_rdata, input, 32: fetched instruction word.
REQ-012 The block SHALL have port pc_out, output, 32: PC of the instruction presented downstream.
REQ-013 The block SHALL have port instruction_out, output, 32: instruction presented downstream.
REQ-014 The block SHALL have port fetch_valid, output, 1: pc_out/instruction_out hold a valid fetched instruction.

Function
REQ-015 The block SHALL implement a 4-state FSM: FETCH, WAIT, HOLD, DRAIN, with at most one memory request outstanding.
REQ-016 The block SHALL drive imem_req=1 only in FETCH and SHALL drive imem_addr equal to the internal pc register.
REQ-017 In FETCH, when imem_ready=1 and redirect=0, the block SHALL go to WAIT; otherwise it SHALL stay in FETCH with the request held stable.
REQ-018 In WAIT, when imem_rvalid=1 and redirect=0, the block SHALL register instruction_out<=imem_rdata, pc_out<=pc and fetch_valid<=1, then go to HOLD.
REQ-019 In HOLD, when PC_Write=1 and redirect=0, the block SHALL set fetch_valid<=0 and pc<=pc+4, then go to FETCH; when PC_Write=0 it SHALL hold all outputs and state.
REQ-020 PC increment SHALL be modulo 2^32: 32'hFFFFFFFC+4 = 32'h00000000.
REQ-021 On redirect=1 in any state, the block SHALL load pc<={redirect_pc[31:2],2'b00}, set fetch_valid<=0 and instruction_out<=32'h00000013, and ignore PC_Write; redirect SHALL take priority over stall.
REQ-022 On a redirect in FETCH with imem_ready=1 (stale request accepted), the block SHALL go to DRAIN; with imem_ready=0 it SHALL stay in FETCH and issue the new address next cycle.
REQ-023 On a redirect in WAIT, the block SHALL go to FETCH if imem_rvalid=1 in the same cycle (the response is discarded), else to DRAIN.
REQ-024 On a redirect in HOLD, the block SHALL go to FETCH.
REQ-025 In DRAIN, on imem_rvalid=1 the block SHALL discard the data and go to FETCH; a further redirect in DRAIN SHALL update pc and keep DRAIN unless rvalid is also 1.
REQ-026 The block SHALL ignore imem_rvalid in FETCH and HOLD.
REQ-027 The block SHALL never present a discarded response on instruction_out or fetch_valid.

Reset
REQ-028 While rst=1 at posedge clk, the block SHALL set pc=RESET_PC, state=FETCH, pc_out=0, instruction_out=32'h00000013 and fetch_valid=0; rst SHALL override redirect and PC_Write.
REQ-029 Reset mid-transaction SHALL abandon any outstanding request; the instruction memory shares rst and SHALL NOT deliver a pre-reset response afterward.
REQ-030 The first imem_req=1 with imem_addr=RESET_PC SHALL appear in the first cycle after rst deasserts.

Verification
REQ-031 The bench SHALL cover basic fetch: after reset, ready=1 and rvalid one cycle later with 0x00500093, PC_Write=1 -> pc_out=0, instruction_out=0x00500093, fetch_valid=1 for 1 cycle, next imem_addr=4.
REQ-032 The bench SHALL cover stall: PC_Write=0 for 5 cycles in HOLD -> outputs unchanged and no imem_req; then PC_Write=1 -> next imem_addr=pc+4.
REQ-033 The bench SHALL cover redirect in WAIT: redirect=1, redirect_pc=0x103 with rvalid late -> DRAIN, late data discarded, then imem_addr=0x100, fetch_valid stays 0 until the new response.
REQ-034 The bench SHALL cover simultaneous events: redirect, rvalid and PC_Write=0 in the same WAIT cycle -> FETCH, fetch_valid=0, instruction_out=0x00000013.
REQ-035 The bench SHALL cover wrap-around: redirect_pc=0xFFFFFFFC, fetch consumed -> next imem_addr=0x00000000.
REQ-036 The bench SHALL cover reset in WAIT: rst=1 for 1 cycle -> all outputs at reset values and next imem_addr=RESET_PC.
